// File: rtl/u712_bus_initiator.sv
`default_nettype none
// ============================================================================
// u712_bus_initiator: MC68040/060 local-bus master sequencer (arbitration,
// nTS/nTIP generation, termination sampling, burst-inhibit split).  Rev 1.0
// ============================================================================
module u712_bus_initiator #(
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 4
) (
    input  logic        CLK40,
    input  logic        nRESET,
    input  logic        REQ,
    input  logic [31:0] REQ_ADDR,
    input  logic        REQ_RnW,
    input  logic        REQ_LINE,
    input  logic [1:0]  REQ_SIZ,
    input  logic [31:0] WDATA,
    output logic [1:0]  BEAT,
    output logic        RD_STB,
    output logic        DONE,
    output logic        ERR,
    output logic        nBR,
    input  logic        nBG,
    input  logic        nBB_IN,
    output logic        nBB_OUT,
    output logic        nBB_OE,
    output logic        nTS,
    output logic        nTIP,
    output logic [31:0] A_OUT,
    output logic        RnW,
    output logic [1:0]  SIZ,
    output logic [1:0]  TT,
    output logic        BUS_OE,
    input  logic [31:0] D_IN,
    output logic [31:0] D_OUT,
    output logic        D_OE,
    input  logic        nTA,
    input  logic        nTEA,
    input  logic        nTBI
);

    localparam int c_tmo_w = $clog2(TIMEOUT + 1);
    localparam int c_rty_w = $clog2(MAX_RETRY + 1);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);
    localparam logic [c_rty_w-1:0] c_rty_last = c_rty_w'(MAX_RETRY - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARB     = 3'd1,
        S_OWN     = 3'd2,
        S_START   = 3'd3,
        S_WAIT    = 3'd4,
        S_RETRY   = 3'd5,
        S_RELEASE = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic               rnw_q, rnw_d;
    logic               line_q, line_d;
    logic [1:0]         siz_q, siz_d;
    logic [1:0]         beat_q, beat_d;
    logic               split_q, split_d;
    logic [c_tmo_w-1:0] tmo_q, tmo_d;
    logic [c_rty_w-1:0] retry_q, retry_d;
    logic               n_br_q, n_br_d;
    logic               n_ts_q, n_ts_d;
    logic               n_tip_q, n_tip_d;
    logic               nbb_out_q, nbb_out_d;
    logic               nbb_oe_q, nbb_oe_d;
    logic               bus_oe_q, bus_oe_d;
    logic               d_oe_q, d_oe_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               w_ack;
    logic               w_tea;
    logic               w_retry;
    logic [1:0]         w_beat_inc;
    logic               w_unused_d_in;

    assign w_ack      = !nTA && nTEA;
    assign w_tea      = nTA && !nTEA;
    assign w_retry    = !nTA && !nTEA;
    assign w_beat_inc = beat_q + 2'd1;

    // Read data is consumed by the client straight from D_IN while RD_STB is high.
    assign w_unused_d_in = ^D_IN;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rnw_d   = rnw_q;
        line_d  = line_q;
        siz_d   = siz_q;
        beat_d  = beat_q;
        split_d = split_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                retry_d = '0;
                if (REQ) begin
                    state_d = S_ARB;
                    addr_d  = REQ_ADDR;
                    rnw_d   = REQ_RnW;
                    line_d  = REQ_LINE;
                    siz_d   = REQ_LINE ? 2'b11 : REQ_SIZ;
                    beat_d  = 2'd0;
                    split_d = 1'b0;
                    tmo_d   = '0;
                end
            end
            S_ARB: begin
                if (!nBG && nBB_IN) begin
                    state_d = S_OWN;
                end
            end
            S_OWN: begin
                state_d = S_START;
            end
            S_START: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (w_ack) begin
                    tmo_d = '0;
                    if (!line_q || beat_q == 2'd3) begin
                        state_d = S_RELEASE;
                        done_d  = 1'b1;
                    end else begin
                        beat_d = w_beat_inc;
                        // Once burst-inhibited, every remaining beat is its own long-word cycle.
                        if (split_q || !nTBI) begin
                            split_d = 1'b1;
                            siz_d   = 2'b00;
                            addr_d  = {addr_q[31:4], w_beat_inc, 2'b00};
                            state_d = S_START;
                        end
                    end
                end else if (w_tea) begin
                    state_d = S_RELEASE;
                    err_d   = 1'b1;
                end else if (w_retry) begin
                    retry_d = retry_q + 1'b1;
                    if (retry_q == c_rty_last) begin
                        state_d = S_RELEASE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_RETRY;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                    if (tmo_q == c_tmo_last) begin
                        state_d = S_RELEASE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RETRY: begin
                state_d = S_START;
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bus-control outputs are registered images of the next state.
        n_br_d    = (state_d != S_ARB);
        n_ts_d    = (state_d != S_START);
        n_tip_d   = !(state_d == S_START || state_d == S_WAIT);
        bus_oe_d  = (state_d inside {S_OWN, S_START, S_WAIT, S_RETRY, S_RELEASE});
        nbb_oe_d  = bus_oe_d;
        nbb_out_d = !(state_d inside {S_OWN, S_START, S_WAIT, S_RETRY});
        d_oe_d    = (state_d == S_WAIT) && !rnw_d;
    end

    always_ff @(posedge CLK40 or negedge nRESET) begin
        if (!nRESET) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rnw_q     <= 1'b1;
            line_q    <= 1'b0;
            siz_q     <= 2'b00;
            beat_q    <= 2'd0;
            split_q   <= 1'b0;
            tmo_q     <= '0;
            retry_q   <= '0;
            n_br_q    <= 1'b1;
            n_ts_q    <= 1'b1;
            n_tip_q   <= 1'b1;
            nbb_out_q <= 1'b1;
            nbb_oe_q  <= 1'b0;
            bus_oe_q  <= 1'b0;
            d_oe_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rnw_q     <= rnw_d;
            line_q    <= line_d;
            siz_q     <= siz_d;
            beat_q    <= beat_d;
            split_q   <= split_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            n_br_q    <= n_br_d;
            n_ts_q    <= n_ts_d;
            n_tip_q   <= n_tip_d;
            nbb_out_q <= nbb_out_d;
            nbb_oe_q  <= nbb_oe_d;
            bus_oe_q  <= bus_oe_d;
            d_oe_q    <= d_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // RD_STB coincides with the clock in which the ack (and D_IN) is sampled.
    assign RD_STB  = (state_q == S_WAIT) && w_ack && rnw_q;
    assign BEAT    = beat_q;
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign nBR     = n_br_q;
    assign nBB_OUT = nbb_out_q;
    assign nBB_OE  = nbb_oe_q;
    assign nTS     = n_ts_q;
    assign nTIP    = n_tip_q;
    assign A_OUT   = addr_q;
    assign RnW     = rnw_q;
    assign SIZ     = siz_q;
    assign TT      = 2'b00;
    assign BUS_OE  = bus_oe_q;
    assign D_OUT   = WDATA;
    assign D_OE    = d_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_u712_bus_initiator.sv
`default_nettype none
// tb_u712_bus_initiator: scoreboard bench for the U712 local-bus initiator.
module tb_u712_bus_initiator;

    logic        CLK40 = 1'b0;
    logic        nRESET = 1'b0;
    logic        REQ = 1'b0;
    logic [31:0] REQ_ADDR = 32'h0;
    logic        REQ_RnW = 1'b1;
    logic        REQ_LINE = 1'b0;
    logic [1:0]  REQ_SIZ = 2'b00;
    logic [31:0] WDATA;
    logic [1:0]  BEAT;
    logic        RD_STB, DONE, ERR, nBR;
    logic        nBG = 1'b1;
    logic        nBB_IN;
    logic        nBB_OUT, nBB_OE, nTS, nTIP;
    logic [31:0] A_OUT;
    logic        RnW;
    logic [1:0]  SIZ, TT;
    logic        BUS_OE;
    logic [31:0] D_IN = 32'h0;
    logic [31:0] D_OUT;
    logic        D_OE;
    logic        nTA = 1'b1, nTEA = 1'b1, nTBI = 1'b1;

    u712_bus_initiator dut (
        .CLK40(CLK40), .nRESET(nRESET), .REQ(REQ), .REQ_ADDR(REQ_ADDR),
        .REQ_RnW(REQ_RnW), .REQ_LINE(REQ_LINE), .REQ_SIZ(REQ_SIZ), .WDATA(WDATA),
        .BEAT(BEAT), .RD_STB(RD_STB), .DONE(DONE), .ERR(ERR), .nBR(nBR),
        .nBG(nBG), .nBB_IN(nBB_IN), .nBB_OUT(nBB_OUT), .nBB_OE(nBB_OE),
        .nTS(nTS), .nTIP(nTIP), .A_OUT(A_OUT), .RnW(RnW), .SIZ(SIZ), .TT(TT),
        .BUS_OE(BUS_OE), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE),
        .nTA(nTA), .nTEA(nTEA), .nTBI(nTBI)
    );

    always #10 CLK40 = ~CLK40;

    assign WDATA  = {16'hC0DE, 14'd0, BEAT};
    assign nBB_IN = nBB_OE ? nBB_OUT : 1'b1;

    localparam int K_ACK = 0;
    localparam int K_TEA = 1;
    localparam int K_RTY = 2;

    typedef struct {
        int          dly;
        int          kind;
        logic        tbi;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  siz;
        logic        rnw;
    } ts_t;

    resp_t       resp_q[$];
    ts_t         ts_q[$];
    logic [1:0]  rd_q[$];
    logic [33:0] wr_q[$];
    logic [1:0]  end_q[$];

    int total = 0;
    int bad   = 0;
    int wcnt  = 0;
    int gcnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic unexp(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event seen, none expected", nm);
    endtask

    task automatic push_resp(input int dly, input int kind, input logic tbi, input logic [31:0] data);
        resp_t r;
        r.dly = dly; r.kind = kind; r.tbi = tbi; r.data = data;
        resp_q.push_back(r);
    endtask

    task automatic push_ts(input logic [31:0] addr, input logic [1:0] siz, input logic rnw);
        ts_t t;
        t.addr = addr; t.siz = siz; t.rnw = rnw;
        ts_q.push_back(t);
    endtask

    // Arbiter: grant two clocks after nBR is seen low, withdraw once nBR negates.
    initial begin
        forever begin
            @(posedge CLK40); #1;
            if (!nBR) begin
                gcnt++;
                if (gcnt >= 2) nBG = 1'b0;
            end else begin
                gcnt = 0;
                nBG  = 1'b1;
            end
        end
    end

    // Responder: terminates after the scripted number of WAIT clocks.
    initial begin
        resp_t r;
        forever begin
            @(posedge CLK40); #1;
            nTA = 1'b1; nTEA = 1'b1; nTBI = 1'b1;
            if (nRESET && !nTIP && nTS) begin
                wcnt++;
                if (resp_q.size() > 0 && wcnt >= resp_q[0].dly) begin
                    r    = resp_q.pop_front();
                    wcnt = 0;
                    nTBI = r.tbi;
                    D_IN = r.data;
                    case (r.kind)
                        K_ACK:   nTA = 1'b0;
                        K_TEA:   nTEA = 1'b0;
                        default: begin nTA = 1'b0; nTEA = 1'b0; end
                    endcase
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: compares every observed bus event against the scoreboard queues.
    initial begin
        ts_t         t;
        logic [1:0]  b;
        logic [33:0] w;
        logic [1:0]  e;
        forever begin
            @(negedge CLK40);
            if (nRESET) begin
                if (!nTS) begin
                    if (ts_q.size() == 0) unexp("nts_pulse");
                    else begin
                        t = ts_q.pop_front();
                        chk("ts_addr", A_OUT, t.addr);
                        chk("ts_siz", 32'(SIZ), 32'(t.siz));
                        chk("ts_rnw", 32'(RnW), 32'(t.rnw));
                        chk("ts_oe_tt_tip", 32'({BUS_OE, nBB_OE, nBB_OUT, nTIP, TT}), 32'b110000);
                    end
                end
                if (RD_STB) begin
                    if (rd_q.size() == 0) unexp("rd_stb");
                    else begin
                        b = rd_q.pop_front();
                        chk("rd_beat", 32'(BEAT), 32'(b));
                    end
                end
                if (!RnW && !nTIP && nTS && !nTA && nTEA) begin
                    if (wr_q.size() == 0) unexp("write_ack");
                    else begin
                        w = wr_q.pop_front();
                        chk("wr_doe", 32'(D_OE), 32'd1);
                        chk("wr_data", D_OUT, w[31:0]);
                        chk("wr_beat", 32'(BEAT), 32'(w[33:32]));
                    end
                end
                if (DONE || ERR) begin
                    if (end_q.size() == 0) unexp("done_err");
                    else begin
                        e = end_q.pop_front();
                        chk("end_code", 32'({DONE, ERR}), 32'(e));
                    end
                end
            end
        end
    end

    task automatic drain_check(input string nm);
        repeat (3) @(posedge CLK40);
        #1;
        chk(nm, 32'(ts_q.size() + rd_q.size() + wr_q.size() + end_q.size() + resp_q.size()), 32'd0);
    endtask

    task automatic run_req(input logic [31:0] a, input logic rnw, input logic line,
                           input logic [1:0] siz, output int lat);
        int  n;
        int  last_ts;
        bit  seen;
        n = 0; last_ts = 0; seen = 0;
        REQ_ADDR = a; REQ_RnW = rnw; REQ_LINE = line; REQ_SIZ = siz; REQ = 1'b1;
        while (!seen && n < 300) begin
            @(posedge CLK40); #1;
            n++;
            if (!nTS) last_ts = n;
            if (DONE || ERR) seen = 1;
        end
        REQ = 1'b0;
        lat = n - last_ts;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL req_end: no DONE/ERR within %0d clocks, required one", n);
        end else begin
            chk("release_hold", 32'({nBB_OE, nBB_OUT, nTIP, D_OE}), 32'b1110);
            @(posedge CLK40); #1;
            chk("release_drop", 32'({nBB_OE, BUS_OE, nBR, DONE, ERR}), 32'b00100);
        end
        drain_check("queues_empty");
    endtask

    initial begin
        int lat;
        int n;
        repeat (3) @(posedge CLK40);
        #1;
        chk("reset_vals", 32'({nBR, nTS, nTIP, nBB_OUT, nBB_OE, BUS_OE, D_OE, DONE, ERR, RD_STB, BEAT}), 32'hF00);
        nRESET = 1'b1;
        @(posedge CLK40); #1;

        // Single long read, ack on third WAIT clock.
        push_ts(32'h00F00010, 2'b00, 1'b1);
        rd_q.push_back(2'd0);
        end_q.push_back(2'b10);
        push_resp(3, K_ACK, 1'b1, 32'hDEADBEEF);
        run_req(32'h00F00010, 1'b1, 1'b0, 2'b00, lat);
        chk("single_lat", 32'(lat), 32'd4);

        // Line write, burst permitted.
        push_ts(32'h08000000, 2'b11, 1'b0);
        wr_q.push_back({2'd0, 32'hC0DE0000});
        wr_q.push_back({2'd1, 32'hC0DE0001});
        wr_q.push_back({2'd2, 32'hC0DE0002});
        wr_q.push_back({2'd3, 32'hC0DE0003});
        end_q.push_back(2'b10);
        repeat (4) push_resp(1, K_ACK, 1'b1, 32'h0);
        run_req(32'h08000000, 1'b0, 1'b1, 2'b00, lat);

        // Line read, burst inhibited on beat 0, split into long-word cycles.
        push_ts(32'h08000020, 2'b11, 1'b1);
        push_ts(32'h08000024, 2'b00, 1'b1);
        push_ts(32'h08000028, 2'b00, 1'b1);
        push_ts(32'h0800002C, 2'b00, 1'b1);
        rd_q.push_back(2'd0); rd_q.push_back(2'd1);
        rd_q.push_back(2'd2); rd_q.push_back(2'd3);
        end_q.push_back(2'b10);
        push_resp(1, K_ACK, 1'b0, 32'h11111111);
        push_resp(1, K_ACK, 1'b1, 32'h22222222);
        push_resp(2, K_ACK, 1'b1, 32'h33333333);
        push_resp(1, K_ACK, 1'b0, 32'h44444444);
        run_req(32'h08000020, 1'b1, 1'b1, 2'b00, lat);

        // Two retries then ack on a single word write.
        repeat (3) push_ts(32'h00F00100, 2'b10, 1'b0);
        wr_q.push_back({2'd0, 32'hC0DE0000});
        end_q.push_back(2'b10);
        push_resp(1, K_RTY, 1'b1, 32'h0);
        push_resp(1, K_RTY, 1'b1, 32'h0);
        push_resp(1, K_ACK, 1'b1, 32'h0);
        run_req(32'h00F00100, 1'b0, 1'b0, 2'b10, lat);

        // Retry limit reached.
        repeat (4) push_ts(32'h00F00200, 2'b01, 1'b1);
        end_q.push_back(2'b01);
        repeat (4) push_resp(1, K_RTY, 1'b1, 32'h0);
        run_req(32'h00F00200, 1'b1, 1'b0, 2'b01, lat);

        // No termination at all: timeout.
        push_ts(32'h00F00300, 2'b00, 1'b1);
        end_q.push_back(2'b01);
        run_req(32'h00F00300, 1'b1, 1'b0, 2'b00, lat);
        chk("timeout_lat", 32'(lat), 32'd65);

        // Bus error on beat 2 of a burst read.
        push_ts(32'h08000040, 2'b11, 1'b1);
        rd_q.push_back(2'd0); rd_q.push_back(2'd1);
        end_q.push_back(2'b01);
        push_resp(1, K_ACK, 1'b1, 32'hAAAA0000);
        push_resp(1, K_ACK, 1'b1, 32'hAAAA0001);
        push_resp(1, K_TEA, 1'b1, 32'h0);
        run_req(32'h08000040, 1'b1, 1'b1, 2'b00, lat);

        // Reset asserted while waiting for termination.
        push_ts(32'h00F00400, 2'b00, 1'b1);
        REQ_ADDR = 32'h00F00400; REQ_RnW = 1'b1; REQ_LINE = 1'b0; REQ_SIZ = 2'b00; REQ = 1'b1;
        n = 0;
        while (nTS && n < 50) begin
            @(posedge CLK40); #1;
            n++;
        end
        chk("rst_reached_start", 32'(nTS), 32'd0);
        repeat (3) @(posedge CLK40);
        #3;
        nRESET = 1'b0;
        REQ    = 1'b0;
        #1;
        chk("rst_mid_wait", 32'({nBR, nTS, nTIP, nBB_OUT, nBB_OE, BUS_OE, D_OE, DONE, ERR, RD_STB, BEAT}), 32'hF00);
        @(posedge CLK40); #1;
        nRESET = 1'b1;
        drain_check("rst_queues_empty");

        // Normal request after reset.
        push_ts(32'h00F00500, 2'b00, 1'b1);
        rd_q.push_back(2'd0);
        end_q.push_back(2'b10);
        push_resp(1, K_ACK, 1'b1, 32'h5A5A5A5A);
        run_req(32'h00F00500, 1'b1, 1'b0, 2'b00, lat);
        chk("post_rst_lat", 32'(lat), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/u712_bus_initiator.md
Name: u712_bus_initiator

Overview:
- MC68040/MC68060 local-bus master sequencer inside U712; the initiator-side counterpart of the transfer-ack logic.
- Takes single-cycle or line (16-byte) requests from an internal client (DMA/PCI bridge).
- Requests and acquires the bus (nBR/nBG/nBB), issues nTS/nTIP, and samples responder termination (nTA, nTEA, nTBI).
- Splits burst-inhibited line transfers into four long-word cycles; reports completion or error to the client.

Parameters:
TIMEOUT, 64, CLK40 cycles to wait for termination per beat before aborting with error
MAX_RETRY, 4, retry terminations tolerated per request before aborting with error

Ports:
CLK40  in  1  bus clock; all bus inputs sampled on rising edge
nRESET  in  1  asynchronous, active-low reset
REQ  in  1  client request; held until DONE or ERR
REQ_ADDR  in  32  request address; line requests use A[3:0]=0
REQ_RnW  in  1  1=read, 0=write
REQ_LINE  in  1  1=line (4 beats), 0=single
REQ_SIZ  in  2  SIZ for single transfers
WDATA  in  32  write data for current BEAT
BEAT  out  2  current beat index
RD_STB  out  1  one-clock strobe: D_IN valid for BEAT (reads)
DONE  out  1  one-clock pulse: request completed
ERR  out  1  one-clock pulse: request aborted (TEA, timeout, retry limit)
nBR  out  1  bus request
nBG  in  1  bus grant
nBB_IN  in  1  bus busy from bus
nBB_OUT, nBB_OE  out  1,1  bus busy drive value/enable
nTS  out  1  transfer start
nTIP  out  1  transfer in progress
A_OUT  out  32  address
RnW  out  1  read/write
SIZ  out  2  transfer size (11=line, 00=long)
TT  out  2  transfer type; always 00 (normal)
BUS_OE  out  1  enables A_OUT/RnW/SIZ/TT/nTS/nTIP drivers
D_IN  in  32  read data
D_OUT  out  32  write data (=WDATA)
D_OE  out  1  data drive enable (writes, from cycle after nTS until termination)
nTA, nTEA, nTBI  in  1,1,1  termination from responder

Behaviour:
- Reset (asynchronous): state IDLE; nBR=1, nTS=1, nTIP=1, nBB_OUT=1, nBB_OE=0, BUS_OE=0, D_OE=0, DONE=0, ERR=0, RD_STB=0, BEAT=0, counters=0.
- IDLE: REQ=1 → ARB; latch address, RnW, LINE, SIZ.
- ARB:
  - nBR=0.
  - nBG=0 and nBB_IN=1 sampled → OWN; nBR stays low until OWN.
- OWN:
  - nBB_OE=1, nBB_OUT=0, BUS_OE=1; drive A/RnW/SIZ/TT.
  - Next clock → START.
- START: nTS=0 for exactly one clock; nTIP=0 from START until termination of last beat; timeout counter cleared → WAIT.
- WAIT: sample each rising edge.
  - nTA=0, nTEA=1 → normal ack.
    - Reads: RD_STB=1 same clock as ack is sampled.
    - Line request, nTBI=1 (burst permitted): stay WAIT for next beat, BEAT+1; no new nTS. After beat 3 ack → RELEASE with DONE.
    - Line request, nTBI=0 on any beat: after this beat, end burst; issue remaining beats as separate long-word cycles (SIZ=00, A[3:2]=BEAT+1 mod 4, A[1:0]=0) via START. Subsequent nTBI ignored.
    - Single request: → RELEASE with DONE.
  - nTEA=0, nTA=1 → bus error: RELEASE with ERR; no RD_STB.
  - nTA=0 and nTEA=0 → retry:
    - retry counter +1.
    - Below MAX_RETRY: negate nTIP one clock, restart from START with the same BEAT/address. Beats already acknowledged are not repeated.
    - At MAX_RETRY → ERR.
  - Neither asserted: timeout counter +1; reaching TIMEOUT → ERR.
- RELEASE:
  - nTIP=1, nBB_OUT=1 driven one clock, then nBB_OE=0 and BUS_OE=0.
  - DONE/ERR pulses here; → IDLE.
  - New request not accepted until IDLE.
- Timing: D_OE deasserts the clock after termination. nBR re-asserts only via ARB.
- nBG negated mid-transfer: ignored until RELEASE; current transfer always completes.
- REQ dropped mid-operation: ignored; the request completes normally.
- nRESET mid-operation: immediate return to reset values; no DONE/ERR.
- Counters:
  - Timeout counter: ceil(log2(TIMEOUT+1)) bits, cleared on each START and each ack.
  - BEAT wraps 3→0 only in the split address calculation.
  - Retry counter cleared in IDLE.

Test Plan:
- Single long read 0x00F00010: nBG=0 after 2 clocks; nTA=0 on 3rd WAIT clock, D_IN=0xDEADBEEF → exactly one nTS pulse, RD_STB with 0xDEADBEEF, DONE once, nBB released 1 clock after termination.
- Line write 0x08000000, nTBI=1, nTA low 4 consecutive clocks → one nTS, BEAT 0..3 with D_OUT following WDATA, SIZ=11, DONE after beat 3.
- Line read 0x08000020, nTBI=0 on beat 0 → 4 nTS pulses, addresses 0x08000020/24/28/2C, SIZ=00 for the 3 follow-ups, 4 RD_STB, DONE.
- Retry: nTA=nTEA=0 twice, then nTA=0 → 3 nTS pulses, same address, DONE; with 4 consecutive retries → ERR, no DONE.
- Timeout/TEA: no termination for 64 clocks → ERR, bus released; separate run with nTEA=0 on beat 2 of a line read → 2 RD_STB, ERR.
- Reset asserted during WAIT → all outputs at reset values immediately; next REQ runs normally.
